// File: rtl/acc_offload_credit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : acc_offload_credit_ctrl
//  Function : per-accelerator outstanding-request credit throttle with
//             drain/flush sequencing for one requester port.
//  Revision : 1.0  initial release
// ============================================================================
module acc_offload_credit_ctrl #(
    parameter int NUM_ACC         = 4,
    parameter int HIER_ADDR_WIDTH = 2,
    parameter int ACC_ADDR_WIDTH  = 3,
    parameter int HIER_LEVEL      = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ACC_IDX_WIDTH   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
    parameter int CNT_WIDTH       = (MAX_OUTSTANDING + 1 > 1) ? $clog2(MAX_OUTSTANDING + 1) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      q_valid_i,
    output logic                                      q_ready_o,
    input  logic [HIER_ADDR_WIDTH+ACC_ADDR_WIDTH-1:0] q_addr_i,
    input  logic                                      q_rsp_exp_i,
    output logic                                      q_valid_o,
    input  logic                                      q_ready_i,
    input  logic                                      p_valid_i,
    input  logic                                      p_ready_i,
    input  logic [ACC_IDX_WIDTH-1:0]                  p_acc_i,
    input  logic                                      p_local_i,
    input  logic                                      flush_i,
    output logic                                      busy_o,
    output logic                                      flush_done_o,
    output logic                                      err_o
);

    localparam int ADDR_WIDTH = HIER_ADDR_WIDTH + ACC_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]       C_MAX_CNT    = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [HIER_ADDR_WIDTH-1:0] C_HIER_LEVEL = HIER_ADDR_WIDTH'(HIER_LEVEL);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt      [NUM_ACC];
    logic [CNT_WIDTH-1:0]  w_cnt_next [NUM_ACC];
    logic                  r_err;

    logic [HIER_ADDR_WIDTH-1:0] w_level;
    logic [ACC_IDX_WIDTH-1:0]   w_sel;
    logic w_local, w_tracked, w_allow, w_issue, w_rsp;
    logic w_sel_full, w_rsp_bad, w_busy, w_all_zero_next;

    assign w_level   = q_addr_i[ADDR_WIDTH-1:ACC_ADDR_WIDTH];
    assign w_sel     = q_addr_i[ACC_IDX_WIDTH-1:0];
    assign w_local   = (w_level == C_HIER_LEVEL) && (32'(w_sel) < NUM_ACC);
    assign w_tracked = w_local && q_rsp_exp_i;

    // Gating looks only at registered counts, so p_* never reaches q_* combinationally.
    assign w_allow   = (r_state == S_RUN) && (!w_tracked || !w_sel_full);
    assign q_valid_o = q_valid_i && w_allow;
    assign q_ready_o = q_ready_i && w_allow;

    assign w_issue = q_valid_o && q_ready_i && w_tracked;
    assign w_rsp   = p_valid_i && p_ready_i && p_local_i;

    always_comb begin
        w_sel_full = 1'b0;
        w_rsp_bad  = 1'b1;
        w_busy     = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if ((w_sel == ACC_IDX_WIDTH'(i)) && (r_cnt[i] >= C_MAX_CNT)) w_sel_full = 1'b1;
            if ((p_acc_i == ACC_IDX_WIDTH'(i)) && (r_cnt[i] != '0))      w_rsp_bad  = 1'b0;
            if (r_cnt[i] != '0)                                           w_busy     = 1'b1;
        end
    end

    always_comb begin
        w_all_zero_next = 1'b1;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (w_cnt_next[i] != '0) w_all_zero_next = 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_ACC; i++) begin : g_cnt
            logic w_inc;
            logic w_dec;
            assign w_inc = w_issue && (w_sel == ACC_IDX_WIDTH'(i));
            // A retire on an empty counter is an error and must not wrap.
            assign w_dec = w_rsp && (p_acc_i == ACC_IDX_WIDTH'(i)) && (r_cnt[i] != '0);
            assign w_cnt_next[i] = r_cnt[i] + CNT_WIDTH'(w_inc) - CNT_WIDTH'(w_dec);

            always_ff @(posedge clk_i) begin
                if (rst_i) r_cnt[i] <= '0;
                else       r_cnt[i] <= w_cnt_next[i];
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (flush_i)         w_state_next = S_DRAIN;
            S_DRAIN: if (w_all_zero_next) w_state_next = S_DONE;
            S_DONE:                       w_state_next = S_RUN;
            default:                      w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_rsp && w_rsp_bad) r_err <= 1'b1;
        end
    end

    assign busy_o       = w_busy;
    assign flush_done_o = (r_state == S_DONE);
    assign err_o        = r_err;

endmodule
`default_nettype wire
